// File: rtl/sic4_sequencer.sv
// Multi-cycle control sequencer for a 4-opcode core: fetch, decode, execute, write-back.
// A fetch that never completes sets a sticky fault and halts the core.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | imem_req high, waiting on imem_ready (bounded by IMEM_TIMEOUT)
// DECODE | imm field registered to the sign extender, ALU controls set up
// EXEC   | ALU controls valid, branch condition sampled
// WB     | register write strobe or branch resolve, pc update
// HALT   | absorbing; only reset leaves
module sic4_sequencer #(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         IMEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ready,
  input  logic [7:0] imem_rdata,
  output logic [1:0] sext_in,
  input  logic [7:0] sext_out,
  output logic [1:0] alu_op,
  output logic       alu_src,
  input  logic       alu_zero,
  output logic       rf_we,
  output logic [1:0] rf_waddr,
  output logic [7:0] pc,
  output logic       busy,
  output logic       halted,
  output logic       fault
);

  localparam int CW = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(IMEM_TIMEOUT - 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_BEQ  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_pc, r_ir;
  logic [1:0]      r_sext_in, r_alu_op, r_rf_waddr;
  logic            r_alu_src, r_zero, r_fault, r_armed;
  logic [CW-1:0]   r_wait;
  logic            w_timeout;
  logic [1:0]      w_op;
  logic            w_unused_rs;

  assign w_op        = r_ir[7:6];
  assign w_unused_rs = ^r_ir[3:2];

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      // r_armed keeps the first fetch at least two edges after reset release
      S_IDLE:   if (start && r_armed) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          w_next = S_DECODE;
        end else if (r_wait == '0) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = (w_op == OP_HALT) ? S_HALT : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= 8'h00;
      r_sext_in  <= 2'b00;
      r_alu_op   <= 2'b00;
      r_alu_src  <= 1'b0;
      r_rf_waddr <= 2'b00;
      r_zero     <= 1'b0;
      r_fault    <= 1'b0;
      r_armed    <= 1'b0;
      r_wait     <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_next == S_FETCH && r_state != S_FETCH)
        r_wait <= WAIT_LOAD;
      else if (r_state == S_FETCH && !imem_ready && r_wait != '0)
        r_wait <= r_wait - 1'b1;
      if (w_timeout) r_fault <= 1'b1;

      case (r_state)
        S_FETCH: if (imem_ready) r_ir <= imem_rdata;
        S_DECODE: begin
          // controls registered here stay put through EXEC and WB
          r_sext_in  <= r_ir[1:0];
          r_rf_waddr <= r_ir[5:4];
          r_alu_op   <= (w_op == OP_BEQ) ? 2'b01 : 2'b00;
          r_alu_src  <= (w_op == OP_ADDI);
        end
        S_EXEC: r_zero <= alu_zero;
        S_WB: begin
          if (w_op == OP_BEQ && r_zero) r_pc <= r_pc + sext_out;
          else                          r_pc <= r_pc + 8'h01;
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign sext_in   = r_sext_in;
  assign alu_op    = r_alu_op;
  assign alu_src   = r_alu_src;
  assign rf_waddr  = r_rf_waddr;
  assign rf_we     = (r_state == S_WB) && (w_op == OP_ADD || w_op == OP_ADDI);
  assign busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted    = (r_state == S_HALT);
  assign fault     = r_fault;

endmodule

// File: doc/sic4_sequencer.md
SIC4_SEQUENCER -- requirements
Module: sic4_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 8: maximum FETCH wait cycles before fault.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  level; leaves IDLE when high.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  8  fetch address; equals pc.
REQ-009 imem_ready  in  1  fetch data valid this cycle.
REQ-010 imem_rdata  in  8  instruction {op[7:6], rd[5:4], rs[3:2], imm[1:0]}.
REQ-011 sext_in  out  2  imm field to the sign extender; registered.
REQ-012 sext_out  in  8  sign-extended imm returned (combinational).
REQ-013 alu_op  out  2  ALU operation: 00 add, 01 sub.
REQ-014 alu_src  out  1  0 = register operand, 1 = sext_out.
REQ-015 alu_zero  in  1  ALU result zero flag.
REQ-016 rf_we  out  1  register-file write strobe, one cycle wide.
REQ-017 rf_waddr  out  2  write register index (rd).
REQ-018 pc  out  8  current program counter.
REQ-019 busy  out  1  high in any state other than IDLE and HALT.
REQ-020 halted  out  1  high in HALT.
REQ-021 fault  out  1  sticky fetch-timeout flag.

Function
REQ-022 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-023 IDLE: all strobes low; on start=1, go to FETCH next cycle.
REQ-024 FETCH: imem_req=1 and imem_addr=pc; on imem_ready=1, latch imem_rdata into ir and go to DECODE.
REQ-025 FETCH: count wait cycles; at IMEM_TIMEOUT cycles without imem_ready, set fault, drop imem_req, and go to HALT.
REQ-026 DECODE: register sext_in <= ir[1:0]; go to EXEC.
REQ-027 EXEC, op 00 (ADD): alu_op=00, alu_src=0.
REQ-028 EXEC, op 01 (ADDI): alu_op=00, alu_src=1.
REQ-029 EXEC, op 10 (BEQ): alu_op=01, alu_src=0; sample alu_zero.
REQ-030 EXEC, op 11 (HALT): go directly to HALT with pc unchanged.
REQ-031 WB, ADD/ADDI: rf_we=1 for exactly one cycle, rf_waddr=ir[5:4], pc <= pc+1.
REQ-032 WB, BEQ: rf_we=0; pc <= pc+sext_out if the sampled alu_zero=1, else pc+1.
REQ-033 WB SHALL go to FETCH.
REQ-034 A non-halting instruction SHALL take 4 cycles from imem_ready to the next imem_req (DECODE, EXEC, WB, FETCH).
REQ-035 PC arithmetic SHALL be 8-bit modulo 256: 8'hFF+1 = 8'h00; 8'h01+8'hFE = 8'hFF.
REQ-036 HALT: absorbing state; start ignored; only rst_n exits.
REQ-037 start SHALL be ignored outside IDLE.
REQ-038 imem_ready outside FETCH SHALL be ignored.
REQ-039 alu_op, alu_src, and rf_waddr SHALL hold their EXEC values through WB.

Reset
REQ-040 On rst_n=0 (async, any state), SHALL enter IDLE with pc=RESET_PC, ir=0, sext_in=0, alu_op=0, alu_src=0, rf_we=0, rf_waddr=0, imem_req=0, busy=0, halted=0, fault=0, and wait counter cleared.
REQ-041 Reset asserted during WB SHALL suppress that cycle's rf_we and pc update.
REQ-042 Exit from reset SHALL be synchronous; the first FETCH SHALL occur no earlier than the second clk edge after rst_n rises with start=1.

Verification
REQ-043 Reset, start=1, fetch ADDI rd=2 imm=2'b11 -> sext_in=2'b11, alu_src=1, rf_we pulses once with rf_waddr=2, pc 00->01.
REQ-044 BEQ imm=2'b10 at pc=8'h05, alu_zero=1 -> pc=8'h03; repeated with alu_zero=0 -> pc=8'h06.
REQ-045 pc=8'hFF, ADD -> pc=8'h00; BEQ imm=2'b01 at 8'hFF, taken -> pc=8'h00.
REQ-046 imem_ready delayed 3 cycles -> imem_req held, no state change; imem_ready never arrives -> fault=1, halted=1 after 8 cycles.
REQ-047 HALT opcode -> halted=1, busy=0, pc unchanged, start pulses ignored; rst_n low -> IDLE, pc=RESET_PC.
REQ-048 rst_n asserted mid-WB of ADD -> no rf_we, pc=RESET_PC immediately without waiting for clk.
